seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, clocked successor to the 8-bit combinational ALU.
- Keeps the 3-bit opcode set and the a_larger/equal/zero/cout flags, and generalises to WIDTH bits.
- Adds registered results, a start/busy/done handshake, and multi-cycle shift-add multiply and restoring divide.
- Sits between the register file and the control FSM; the controller issues one operation at a time.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- opcode  input  3  operation select, sampled on accept.
- cin  input  1  carry/borrow in for ADD/SUB, sampled on accept.
- a  input  WIDTH  operand A, sampled on accept.
- b  input  WIDTH  operand B, sampled on accept.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when results become valid.
- c  output  WIDTH  result (low product half / quotient).
- c_hi  output  WIDTH  high product half / remainder; 0 for other ops.
- cout  output  1  carry/borrow/overflow flag.
- a_larger  output  1  latched a > b, unsigned.
- equal  output  1  latched a == b.
- zero  output  1  result is zero (see rules).
- err  output  1  divide by zero.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, FSM → IDLE; aborts any in-flight operation, and no done is produced for it.
- Accept: edge with start=1 and busy=0. Operands, opcode and cin are captured; later input changes have no effect. start while busy=1 is ignored (not queued).
- Opcodes:
  - 000 ADD: {cout,c} = a+b+cin.
  - 001 SUB: c = a-b-cin mod 2^WIDTH; cout=1 iff a < b+cin (borrow).
  - 010 AND, 011 OR, 100 XOR.
  - 101 SHL: c = a << b[log2(WIDTH)-1:0]; cout = last bit shifted out (0 when shift = 0).
  - 110 MUL: unsigned; {c_hi,c} = a*b; cout = (c_hi != 0).
  - 111 DIV: unsigned; c = a/b, c_hi = a%b; cout = 0.
- Logic/shift ops force cout=0 except SHL as above; c_hi=0 for all ops except MUL/DIV.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE on accepting opcodes 000–101 or DIV with b=0.
  - IDLE → MUL / DIV otherwise; busy=1 from the cycle after accept.
  - MUL / DIV: one bit per cycle for exactly WIDTH cycles, then → DONE.
  - DONE: result registers updated, done=1 for one cycle, busy=0, → IDLE. A new start may be accepted in the DONE cycle.
- Latency, accept edge to done=1: 1 cycle for single-cycle ops and divide-by-zero; WIDTH+1 cycles for MUL/DIV.
- Back-to-back single-cycle ops with start held high give done on every cycle.
- Outputs hold their last values until the next DONE; they do not change while busy.
- Divide by zero: c = all ones, c_hi = a, err=1, cout=0. err clears on the next completed operation.
- a_larger/equal come from the latched operands and update at DONE for every opcode.
- zero: (c==0) for non-MUL ops; ({c_hi,c}==0) for MUL.
- busy and done are never both 1.

Test Plan:
- WIDTH=8, ADD a=0xAA b=0xCC cin=0 → done 1 cycle after accept; c=0x76, cout=1, a_larger=0, equal=0, zero=0.
- SUB a=0xAA b=0xCC cin=0 → c=0xDE, cout=1. Then XOR same operands → c=0x66, cout=0. Then SUB a=b=0xAB → c=0, zero=1, equal=1.
- MUL a=0xAA b=0xCC → busy for 8 cycles; done exactly 9 cycles after accept; c=0x78, c_hi=0x87, cout=1. start pulses while busy are ignored and the result is unchanged.
- DIV a=200 b=7 → done after 9 cycles; c=28, c_hi=4, err=0. Then DIV a=0x55 b=0 → done after 1 cycle; c=0xFF, c_hi=0x55, err=1.
- Assert rst at cycle 4 of a MUL → next cycle all outputs 0, busy=0, no done. A fresh ADD a=1 b=1 cin=1 → c=3, cout=0.
- SHL a=0x81 b=1 → c=0x02, cout=1. WIDTH=16 MUL a=0xFFFF b=0xFFFF → c=0x0001, c_hi=0xFFFE, done after 17 cycles.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: clocked WIDTH-bit ALU with a start/busy/done handshake.
// Single-cycle ops complete one cycle after accept. MUL (shift-add) and
// DIV (restoring) take one bit per cycle for WIDTH cycles.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// MUL    | shift-add multiply in progress, one multiplier bit per cycle
// DIV    | restoring divide in progress, one quotient bit per cycle
// DONE   | results just updated, done=1, a new start may be accepted
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_hi,
  output logic             cout,
  output logic             a_larger,
  output logic             equal,
  output logic             zero,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  // hi/lo hold the running product (hi:lo) or remainder/dividend-quotient
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [WIDTH-1:0] c_q, c_d, c_hi_q, c_hi_d;
  logic             cout_q, cout_d, a_larger_q, a_larger_d;
  logic             equal_q, equal_d, zero_q, zero_d, err_q, err_d;

  logic             accept;
  logic [WIDTH:0]   add_w, sub_w, shl_w;
  logic [WIDTH-1:0] sc_c, sc_hi;
  logic             sc_cout, sc_err;

  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_cat;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_tmp, div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem, div_lo;

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = (state_q == S_DONE);
  assign accept   = start && !busy;
  assign c        = c_q;
  assign c_hi     = c_hi_q;
  assign cout     = cout_q;
  assign a_larger = a_larger_q;
  assign equal    = equal_q;
  assign zero     = zero_q;
  assign err      = err_q;

  // Single-cycle results straight from the operands being accepted
  always_comb begin
    add_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sub_w   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    shl_w   = {1'b0, a} << b[SW-1:0];
    sc_c    = '0;
    sc_hi   = '0;
    sc_cout = 1'b0;
    sc_err  = 1'b0;
    case (opcode)
      OP_ADD: begin sc_c = add_w[WIDTH-1:0]; sc_cout = add_w[WIDTH]; end
      // bit WIDTH of the extended difference is set exactly when a < b+cin
      OP_SUB: begin sc_c = sub_w[WIDTH-1:0]; sc_cout = sub_w[WIDTH]; end
      OP_AND: sc_c = a & b;
      OP_OR:  sc_c = a | b;
      OP_XOR: sc_c = a ^ b;
      OP_SHL: begin sc_c = shl_w[WIDTH-1:0]; sc_cout = shl_w[WIDTH]; end
      // only reached as a single-cycle op when b == 0
      OP_DIV: begin sc_c = '1; sc_hi = a; sc_err = 1'b1; end
      default: ;
    endcase
  end

  // One shift-add multiply step and one restoring divide step
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    mul_cat = {mul_sum, lo_q};
    mul_hi  = mul_cat[2*WIDTH:WIDTH+1];
    mul_lo  = mul_cat[WIDTH:1];
    div_tmp = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_tmp >= {1'b0, b_q});
    div_sub = div_tmp - {1'b0, b_q};
    div_rem = div_ge ? div_sub[WIDTH-1:0] : div_tmp[WIDTH-1:0];
    div_lo  = {lo_q[WIDTH-2:0], div_ge};
  end

  // Next-state and result-register update logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    c_d        = c_q;
    c_hi_d     = c_hi_q;
    cout_d     = cout_q;
    a_larger_d = a_larger_q;
    equal_d    = equal_q;
    zero_d     = zero_q;
    err_d      = err_q;
    case (state_q)
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (state_q == S_MUL) begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end else begin
          hi_d = div_rem;
          lo_d = div_lo;
        end
        if (cnt_q == CW'(1)) begin
          state_d    = S_DONE;
          a_larger_d = (a_q > b_q);
          equal_d    = (a_q == b_q);
          err_d      = 1'b0;
          if (state_q == S_MUL) begin
            c_d    = mul_lo;
            c_hi_d = mul_hi;
            cout_d = (mul_hi != '0);
            zero_d = ({mul_hi, mul_lo} == '0);
          end else begin
            c_d    = div_lo;
            c_hi_d = div_rem;
            cout_d = 1'b0;
            zero_d = (div_lo == '0);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          a_d   = a;
          b_d   = b;
          cnt_d = CW'(WIDTH);
          hi_d  = '0;
          if (opcode == OP_MUL) begin
            state_d = S_MUL;
            lo_d    = b;
          end else if (opcode == OP_DIV && b != '0) begin
            state_d = S_DIV;
            lo_d    = a;
          end else begin
            state_d    = S_DONE;
            c_d        = sc_c;
            c_hi_d     = sc_hi;
            cout_d     = sc_cout;
            err_d      = sc_err;
            zero_d     = (sc_c == '0);
            a_larger_d = (a > b);
            equal_d    = (a == b);
          end
        end
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      c_q        <= '0;
      c_hi_q     <= '0;
      cout_q     <= 1'b0;
      a_larger_q <= 1'b0;
      equal_q    <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      c_q        <= c_d;
      c_hi_q     <= c_hi_d;
      cout_q     <= cout_d;
      a_larger_q <= a_larger_d;
      equal_q    <= equal_d;
      zero_q     <= zero_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu at WIDTH=8 and WIDTH=16,
// compared against an arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, al8, eq8, z8, err8;
  logic [7:0] c8, chi8;

  logic        start16 = 1'b0, cin16 = 1'b0;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, al16, eq16, z16, err16;
  logic [15:0] c16, chi16;

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .opcode(op8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .c(c8), .c_hi(chi8),
    .cout(cout8), .a_larger(al8), .equal(eq8), .zero(z8), .err(err8));

  seq_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .opcode(op16), .cin(cin16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .c(c16), .c_hi(chi16),
    .cout(cout16), .a_larger(al16), .equal(eq16), .zero(z16), .err(err16));

  int n_cmp = 0;
  int n_bad = 0;
  longint prev_c = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic on the operation definitions
  task automatic model(input int w, input int op, input longint av, input longint bv,
                       input int ci, output longint ec, output longint ehi,
                       output longint eco, output longint ez, output longint ee,
                       output longint el);
    longint mask, p, s;
    mask = (64'd1 << w) - 1;
    ec = 0; ehi = 0; eco = 0; ee = 0; el = 1;
    case (op)
      0: begin p = av + bv + ci; ec = p & mask; eco = (p >> w) & 1; end
      1: begin ec = (av - bv - ci) & mask; eco = (av < bv + ci) ? 1 : 0; end
      2: ec = av & bv;
      3: ec = av | bv;
      4: ec = av ^ bv;
      5: begin
        s = bv & (w - 1);
        ec = (av << s) & mask;
        eco = (s == 0) ? 0 : ((av >> (w - s)) & 1);
      end
      6: begin
        p = av * bv; ec = p & mask; ehi = p >> w; eco = (ehi != 0) ? 1 : 0;
        el = w + 1;
      end
      default: begin
        if (bv == 0) begin ec = mask; ehi = av; ee = 1; end
        else begin ec = av / bv; ehi = av % bv; el = w + 1; end
      end
    endcase
    if (op == 6) ez = (ec == 0 && ehi == 0) ? 1 : 0;
    else         ez = (ec == 0) ? 1 : 0;
  endtask

  task automatic run8(input int op, input longint av, input longint bv, input int ci,
                      input bit pulse);
    longint ec, ehi, eco, ez, ee, el;
    int lat;
    model(8, op, av, bv, ci, ec, ehi, eco, ez, ee, el);
    @(negedge clk);
    start8 = 1'b1; op8 = op[2:0]; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci[0];
    @(posedge clk); #1;
    a8 = $urandom; b8 = $urandom; op8 = $urandom; cin8 = $urandom;
    start8 = pulse && busy8 && $urandom_range(0, 1) == 1;
    lat = 1;
    while (!done8 && lat < 40) begin
      if (busy8) chk("hold_c", c8, prev_c);
      @(posedge clk); #1;
      lat++;
      if (busy8 && done8) chk("busy_and_done", 1, 0);
      start8 = pulse && busy8 && $urandom_range(0, 1) == 1;
    end
    start8 = 1'b0;
    chk("latency", lat, el);
    chk("c", c8, ec);
    chk("c_hi", chi8, ehi);
    chk("cout", cout8, eco);
    chk("zero", z8, ez);
    chk("err", err8, ee);
    chk("a_larger", al8, (av > bv) ? 1 : 0);
    chk("equal", eq8, (av == bv) ? 1 : 0);
    chk("busy_at_done", busy8, 0);
    prev_c = ec;
  endtask

  task automatic run16(input int op, input longint av, input longint bv, input int ci);
    longint ec, ehi, eco, ez, ee, el;
    int lat;
    model(16, op, av, bv, ci, ec, ehi, eco, ez, ee, el);
    @(negedge clk);
    start16 = 1'b1; op16 = op[2:0]; a16 = av[15:0]; b16 = bv[15:0]; cin16 = ci[0];
    @(posedge clk); #1;
    start16 = 1'b0; a16 = $urandom; b16 = $urandom;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w16_latency", lat, el);
    chk("w16_c", c16, ec);
    chk("w16_c_hi", chi16, ehi);
    chk("w16_cout", cout16, eco);
    chk("w16_zero", z16, ez);
    chk("w16_err", err16, ee);
  endtask

  initial begin
    longint ec, ehi, eco, ez, ee, el, av, bv;
    int op, ci;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c", c8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_flags", {cout8, al8, eq8, z8, err8}, 0);
    @(negedge clk); rst = 1'b0;

    run8(0, 'hAA, 'hCC, 0, 0);
    run8(1, 'hAA, 'hCC, 0, 0);
    run8(4, 'hAA, 'hCC, 0, 0);
    run8(1, 'hAB, 'hAB, 0, 0);
    run8(6, 'hAA, 'hCC, 0, 1);
    run8(7, 200, 7, 0, 1);
    run8(7, 'h55, 0, 0, 0);
    run8(5, 'h81, 1, 0, 0);
    run8(5, 'h81, 0, 0, 0);
    run8(0, 'hFF, 'h00, 1, 0);
    run8(1, 'h00, 'hFF, 1, 0);

    // reset in the middle of a multiply: no done, everything cleared
    @(negedge clk);
    start8 = 1'b1; op8 = 3'd6; a8 = 8'hAA; b8 = 8'hCC;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_out", {c8, chi8, cout8, al8, eq8, z8, err8}, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", done8, 0);
    end
    prev_c = 0;
    run8(0, 1, 1, 1, 0);

    // back-to-back single-cycle ops with start held high
    for (int i = 0; i < 10; i++) begin
      op = $urandom_range(0, 5);
      av = $urandom_range(0, 255); bv = $urandom_range(0, 255); ci = $urandom_range(0, 1);
      model(8, op, av, bv, ci, ec, ehi, eco, ez, ee, el);
      @(negedge clk);
      start8 = 1'b1; op8 = op[2:0]; a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci[0];
      @(posedge clk); #1;
      chk("b2b_done", done8, 1);
      chk("b2b_c", c8, ec);
      chk("b2b_cout", cout8, eco);
      prev_c = ec;
    end
    @(negedge clk); start8 = 1'b0;

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      av = $urandom_range(0, 255);
      bv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) bv = av;
      run8(op, av, bv, $urandom_range(0, 1), $urandom_range(0, 1) == 1);
    end

    run16(6, 'hFFFF, 'hFFFF, 0);
    run16(7, 'hFFFF, 3, 0);
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 7);
      bv = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 65535);
      run16(op, $urandom_range(0, 65535), bv, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
